// File: rtl/sysmgr_pkg.sv
// -----------------------------------------------------------------------------
// sysmgr_pkg
// Shared definitions for the system-manager PLL power-up sequencer:
//   - state_t : sequencer state encoding
//   - cnt_width() : width of the shared sequencing counter, sized from the
//                   largest timing parameter plus one bit of headroom
// -----------------------------------------------------------------------------
package sysmgr_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sysmgr_sync2.sv
// -----------------------------------------------------------------------------
// sysmgr_sync2
// Two-flop synchronizer for a single asynchronous level, cleared to 0 by the
// asynchronous active-low reset. Output latency is two clk edges.
// Ports:
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input level
//   q_o    : synchronized level
// -----------------------------------------------------------------------------
module sysmgr_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sysmgr_seq.sv
// -----------------------------------------------------------------------------
// sysmgr_seq
// Power-up and recovery sequencer for the iCE40 PLL. Holds the PLL in reset,
// waits for a qualified LOCK, then releases N_STAGES active-high domain resets
// one at a time. Lock loss or seq_req re-sequences; MAX_RETRY consecutive lock
// timeouts park the block in a sticky fault state.
// Ports:
//   clk         : free-running 12 MHz reference clock
//   rst_n       : asynchronous active-low reset
//   pll_lock    : raw PLL LOCK (asynchronous)
//   seq_req     : single-cycle pulse requesting a full re-sequence
//   pll_reset_n : PLL RESETB
//   rst_stage   : active-high domain resets, bit 0 released first
//   ready       : high while all stages are released
//   fail        : sticky fault flag
//   retry_cnt   : failed lock attempts in the current sequence
// -----------------------------------------------------------------------------
module sysmgr_seq
  import sysmgr_pkg::*;
#(
  parameter int N_STAGES     = 2,
  parameter int RST_HOLD     = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_STABLE  = 256,
  parameter int STAGE_GAP    = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pll_lock,
  input  logic                seq_req,
  output logic                pll_reset_n,
  output logic [N_STAGES-1:0] rst_stage,
  output logic                ready,
  output logic                fail,
  output logic [3:0]          retry_cnt
);

  localparam int CW    = cnt_width(RST_HOLD, LOCK_TIMEOUT, LOCK_STABLE, STAGE_GAP);
  localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  // The counter is cleared on every state entry and counts down, so after k
  // cycles in a state it holds -k. A state's time is up when it reaches
  // -(duration-1); these are those terminal values.
  localparam logic [CW-1:0] LIM_HOLD    = CW'(1 - RST_HOLD);
  localparam logic [CW-1:0] LIM_TIMEOUT = CW'(1 - LOCK_TIMEOUT);
  localparam logic [CW-1:0] LIM_STABLE  = CW'(1 - LOCK_STABLE);
  localparam logic [CW-1:0] LIM_GAP     = CW'(1 - STAGE_GAP);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_STAGES - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [3:0]           retry_q, retry_d;
  logic                 pll_reset_n_q, pll_reset_n_d;
  logic [N_STAGES-1:0]  stage_q, stage_d;
  logic                 ready_q, ready_d;
  logic                 fail_q, fail_d;
  logic                 lock_s;
  logic                 restart;

  sysmgr_sync2 u_lock_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (pll_lock),
    .q_o    (lock_s)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    restart = 1'b0;
    cnt_d   = cnt_q - CW'(1);

    if (seq_req) begin
      // Highest priority: overrides lock drops and counter expiry, and
      // restarts the sequence even when already in PLL_RST.
      state_d = ST_PLL_RST;
      retry_d = '0;
      restart = 1'b1;
    end else begin
      unique case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == LIM_HOLD) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == LIM_TIMEOUT) begin
            retry_d = retry_q + 4'd1;
            state_d = (retry_d == 4'(MAX_RETRY)) ? ST_FAIL : ST_PLL_RST;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == LIM_STABLE) begin
            state_d = ST_RELEASE;
            idx_d   = '0;
          end
        end
        ST_RELEASE: begin
          if (!lock_s) begin
            state_d = ST_PLL_RST;
          end else if (cnt_q == LIM_GAP) begin
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              restart = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!lock_s) state_d = ST_PLL_RST;
        end
        ST_FAIL: begin
        end
        default: state_d = ST_PLL_RST;
      endcase
    end

    if (state_d == ST_RUN) retry_d = '0;
    if ((state_d != state_q) || restart) cnt_d = '0;

    // Outputs are decoded from the next state and registered, so they change
    // only on clk edges and never glitch.
    pll_reset_n_d = !((state_d == ST_PLL_RST) || (state_d == ST_FAIL));
    ready_d       = (state_d == ST_RUN);
    fail_d        = (state_d == ST_FAIL);
    stage_d       = '1;
    if (state_d == ST_RUN) begin
      stage_d = '0;
    end else if (state_d == ST_RELEASE) begin
      // Every stage up to and including idx is released; earlier stages stay
      // released as idx advances, keeping the bits monotonic.
      for (int i = 0; i < N_STAGES; i++) begin
        if (i <= int'(idx_d)) stage_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_PLL_RST;
      cnt_q         <= '0;
      idx_q         <= '0;
      retry_q       <= '0;
      pll_reset_n_q <= 1'b0;
      stage_q       <= '1;
      ready_q       <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      retry_q       <= retry_d;
      pll_reset_n_q <= pll_reset_n_d;
      stage_q       <= stage_d;
      ready_q       <= ready_d;
      fail_q        <= fail_d;
    end
  end

  assign pll_reset_n = pll_reset_n_q;
  assign rst_stage   = stage_q;
  assign ready       = ready_q;
  assign fail        = fail_q;
  assign retry_cnt   = retry_q;

endmodule
